// File: rtl/oh_simsched.sv
// Simulation scoreboard sequencer: buffers a reference stream, compares each
// accepted result against the buffered head, and reports a per-run verdict.
module oh_simsched #(
    parameter int DW      = 32,
    parameter int CW      = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          start_i,
    input  logic [CW-1:0] num_i,
    input  logic          ref_valid_i,
    input  logic [DW-1:0] ref_data_i,
    output logic          ref_ready_o,
    input  logic          res_valid_i,
    input  logic [DW-1:0] res_data_i,
    output logic          res_ready_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          pass_o,
    output logic          diff_o,
    output logic [CW-1:0] err_count_o,
    output logic [CW-1:0] first_err_idx_o,
    output logic          timeout_flag_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = AW + 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [OW-1:0] occ_q, occ_d;
    logic [CW-1:0] num_q, ref_cnt_q, res_cnt_q, res_cnt_d;
    logic [CW-1:0] err_count_q, first_err_idx_q;
    logic [WW-1:0] wdog_q;
    logic          timeout_q, diff_q;

    logic push, pop, mismatch, buf_full, buf_empty;

    assign buf_full  = (occ_q == OW'(DEPTH));
    assign buf_empty = (occ_q == '0);

    // Readiness looks only at registered occupancy, so a full buffer never
    // accepts a reference even when a result pops in the same cycle.
    assign ref_ready_o = (state_q == RUN) && !buf_full && (ref_cnt_q < num_q);
    assign res_ready_o = (state_q == RUN) && !buf_empty;

    assign push      = ref_valid_i && ref_ready_o;
    assign pop       = res_valid_i && res_ready_o;
    assign mismatch  = pop && (res_data_i != mem_q[rd_ptr_q]);
    assign res_cnt_d = res_cnt_q + 1'b1;

    always_comb begin
        occ_d = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= ref_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q         <= IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            occ_q           <= '0;
            num_q           <= '0;
            ref_cnt_q       <= '0;
            res_cnt_q       <= '0;
            err_count_q     <= '0;
            first_err_idx_q <= '0;
            wdog_q          <= '0;
            timeout_q       <= 1'b0;
            diff_q          <= 1'b0;
        end else begin
            diff_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        wr_ptr_q        <= '0;
                        rd_ptr_q        <= '0;
                        occ_q           <= '0;
                        num_q           <= num_i;
                        ref_cnt_q       <= '0;
                        res_cnt_q       <= '0;
                        err_count_q     <= '0;
                        first_err_idx_q <= '0;
                        wdog_q          <= '0;
                        timeout_q       <= 1'b0;
                        state_q         <= (num_i != '0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    occ_q <= occ_d;
                    if (push) begin
                        wr_ptr_q  <= wr_ptr_q + 1'b1;
                        ref_cnt_q <= ref_cnt_q + 1'b1;
                    end
                    if (pop) begin
                        rd_ptr_q  <= rd_ptr_q + 1'b1;
                        res_cnt_q <= res_cnt_d;
                        wdog_q    <= '0;
                        if (mismatch) begin
                            diff_q <= 1'b1;
                            if (err_count_q != '1) begin
                                err_count_q <= err_count_q + 1'b1;
                            end
                            if (err_count_q == '0) begin
                                first_err_idx_q <= res_cnt_q;
                            end
                        end
                        if (res_cnt_d == num_q) begin
                            state_q <= DONE;
                        end
                    end else if (wdog_q == WW'(TIMEOUT - 1)) begin
                        // Watchdog expiry abandons whatever is still buffered.
                        timeout_q <= 1'b1;
                        state_q   <= DONE;
                        wr_ptr_q  <= '0;
                        rd_ptr_q  <= '0;
                        occ_q     <= '0;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o          = (state_q == RUN);
    assign done_o          = (state_q == DONE);
    assign pass_o          = (state_q == DONE) && (err_count_q == '0) && !timeout_q;
    assign diff_o          = diff_q;
    assign err_count_o     = err_count_q;
    assign first_err_idx_o = first_err_idx_q;
    assign timeout_flag_o  = timeout_q;

endmodule
